digest_prefix_matcher: RTL
==========================

# digest_prefix_matcher

Downstream stage of the SHA-1 core in the collision-search datapath. Each time the core presents a digest, the block compares that digest against a stored reference digest and counts how many leading bits (MSB first) are equal. It raises a hit when that count meets a per-digest target. It replaces the single-cycle 160-bit compare with a word-serial compare: one 32-bit word per cycle, which keeps timing closure easy at the Nios custom-instruction clock.

## Interface
- DIGEST_W, 160, digest width in bits; must equal NUM_WORDS × WORD_W
- WORD_W, 32, bits compared per cycle
- MATCH_W, 8, width of match count and target
- CNT_W, 16, width of the saturating hit counter

- iClk  in  1  clock; all logic on its rising edge
- iReset_n  in  1  synchronous, active-low reset
- iLoadRef  in  1  capture iDigest as the reference (honoured only in IDLE)
- iValid  in  1  1-cycle pulse: iDigest/iTarget hold a digest to test
- iDigest  in  DIGEST_W  digest; bit 159 is the MSB of word 0
- iTarget  in  MATCH_W  required leading-match bits, sampled with iValid
- iClearCount  in  1  clear oHitCount
- oBusy  out  1  high while not IDLE
- oDone  out  1  1-cycle pulse: result valid
- oHit  out  1  oMatchBits ≥ latched target; held until next oDone
- oMatchBits  out  MATCH_W  leading equal bits, 0..160; held until next oDone
- oHitCount  out  CNT_W  number of hits, saturating
- oOverrun  out  1  1-cycle pulse: an iValid was dropped

## Operation
- FSM states: IDLE, COMPARE, REPORT.
- IDLE:
  - iLoadRef=1: reference ← iDigest.
  - else iValid=1: latch the digest and target; word index ← 0; accumulator ← 0; go to COMPARE.
- COMPARE (word index k):
  - x = ref_word[k] XOR dig_word[k]; z = leading zero count of x (0..32).
  - accumulator += z.
  - If z < 32 (mismatch) or k = 4, the final count is known; otherwise k+1.
- Transition to REPORT:
  - Without the config macro: always after k = 4; later words do not add to the accumulator once a mismatch is seen.
  - With the config macro: immediately after the mismatching word.
- REPORT:
  - oDone=1; oMatchBits ← accumulator; oHit ← (accumulator ≥ target).
  - Hit counter increments on a hit and saturates at 2^CNT_W−1.
  - Next state is IDLE.
- Target handling: target 0 always hits; target > 160 never hits (unsigned compare, no special casing).
- Dropped requests: iValid outside IDLE, or iValid together with iLoadRef in IDLE → request dropped, oOverrun pulses the next cycle. iLoadRef outside IDLE is ignored silently.
- iClearCount: clears the counter and takes priority over a same-cycle increment.
- Reset: every output and register goes to 0 (oHit=0, oMatchBits=0, oHitCount=0, reference=0, state IDLE). Reset during COMPARE aborts the compare with no oDone.

## Timing
- Request: iValid sampled at edge t.
- COMPARE occupies cycles t+1..t+5 without the macro; oDone is high in cycle t+6. Latency is fixed at 6.
- With the macro and a mismatch in word k: oDone in cycle t+2+k. Full match: t+6.
- Throughput: the next iValid is accepted in the cycle after oDone (oBusy=0). Back-to-back period is 7 cycles without the macro.
- A reference loaded at edge t is used by an iValid accepted at t+1 or later.

## Configuration
- DIGEST_PREFIX_MATCHER_EARLY_EXIT_EN:
  - Defined: COMPARE ends at the first mismatching word; latency 2..6.
  - Undefined: constant latency 6, so SHA-1 pipeline scheduling stays deterministic.
  - oMatchBits, oHit and oHitCount are identical in both builds.

## Structure
- Shared package `collision_pkg`:
  - DIGEST_W, WORD_W, NUM_WORDS=5, MATCH_W
  - FSM state typedef (IDLE/COMPARE/REPORT)
- Sub-module `lzc32`: combinational 32-bit leading-zero counter (output 0..32; all-zero input → 32), instantiated once on the XOR word.

## Test plan
- ref=0, digest=0, target=160 → oDone at t+6, oMatchBits=160, oHit=1, oHitCount=1.
- ref=0, digest=0x8000…0, target=0 → oMatchBits=0, oHit=1; with the macro oDone at t+2.
- ref=0, digest with only bit 127 set (word 1 MSB), target=33 → oMatchBits=32, oHit=0; oDone at t+3 with the macro, t+6 without.
- iValid pulsed at t+2 during a compare → oOverrun=1 at t+3; the first result is unchanged; no second oDone.
- iReset_n=0 at t+3 → no oDone; all outputs 0 the next cycle; a fresh iValid then completes normally.
- Three hits → oHitCount=3; iClearCount together with a REPORT hit → oHitCount=0.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared definitions for the collision-search datapath.
// Holds the digest/word geometry, count widths and the matcher FSM state type.
package collision_pkg;

  localparam int DIGEST_W  = 160; // digest width in bits
  localparam int WORD_W    = 32;  // bits compared per cycle
  localparam int NUM_WORDS = 5;   // DIGEST_W / WORD_W
  localparam int MATCH_W   = 8;   // width of match count and target
  localparam int CNT_W     = 16;  // width of the saturating hit counter
  localparam int IDX_W     = 3;   // word index width (0..NUM_WORDS-1)
  localparam int LZ_W      = 6;   // leading-zero count width (0..32)

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    REPORT  = 2'd2
  } state_t;

endpackage

// File: rtl/digest_prefix_matcher_if.sv
// Request/result bundle of the digest prefix matcher.
// master: producer of digests (drives iLoadRef, iValid, iDigest, iTarget,
//         iClearCount; observes the results).
// slave : the matcher (observes requests; drives oBusy, oDone, oHit,
//         oMatchBits, oHitCount, oOverrun).
interface digest_prefix_matcher_if;
  import collision_pkg::*;

  logic                iLoadRef;
  logic                iValid;
  logic [DIGEST_W-1:0] iDigest;
  logic [MATCH_W-1:0]  iTarget;
  logic                iClearCount;
  logic                oBusy;
  logic                oDone;
  logic                oHit;
  logic [MATCH_W-1:0]  oMatchBits;
  logic [CNT_W-1:0]    oHitCount;
  logic                oOverrun;

  modport master (
    output iLoadRef, iValid, iDigest, iTarget, iClearCount,
    input  oBusy, oDone, oHit, oMatchBits, oHitCount, oOverrun
  );

  modport slave (
    input  iLoadRef, iValid, iDigest, iTarget, iClearCount,
    output oBusy, oDone, oHit, oMatchBits, oHitCount, oOverrun
  );

endinterface

// File: rtl/digest_prefix_matcher_lzc32.sv
// lzc32: combinational 32-bit leading-zero counter.
// Ports: value (32-bit input), count (0..32; an all-zero input gives 32).
module lzc32
  import collision_pkg::*;
(
  input  logic [WORD_W-1:0] value,
  output logic [LZ_W-1:0]   count
);

  // Scan from LSB to MSB so the highest set bit is the last one to write.
  always_comb begin
    count = LZ_W'(WORD_W);
    for (int i = 0; i < WORD_W; i++) begin
      if (value[i]) count = LZ_W'(WORD_W - 1 - i);
    end
  end

endmodule

// File: rtl/digest_prefix_matcher.sv
// digest_prefix_matcher: counts how many leading bits (MSB first) of an
// incoming digest equal a stored reference, one 32-bit word per cycle, and
// flags a hit when that count reaches the per-digest target.
// Ports: iClk (clock), iReset_n (synchronous active-low reset),
//        bus (digest_prefix_matcher_if.slave: requests in, results out).
// Build option: define DIGEST_PREFIX_MATCHER_EARLY_EXIT_EN to leave COMPARE
// at the first mismatching word (latency 2..6); otherwise latency is fixed 6.
module digest_prefix_matcher
  import collision_pkg::*;
(
  input  logic                    iClk,
  input  logic                    iReset_n,
  digest_prefix_matcher_if.slave  bus
);

  state_t               state_reg, state_next;
  logic [DIGEST_W-1:0]  ref_reg;
  // Holds ref XOR digest; shifted left one word per COMPARE cycle so the
  // word under test is always the top 32 bits.
  logic [DIGEST_W-1:0]  diff_reg;
  logic [MATCH_W-1:0]   target_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [MATCH_W-1:0]   acc_reg;
  logic                 mismatch_seen_reg;
  logic [MATCH_W-1:0]   match_reg;
  logic                 hit_reg;
  logic [CNT_W-1:0]     count_reg;
  logic                 overrun_reg;

  logic [LZ_W-1:0]      lz_count;
  logic                 word_mismatch;
  logic                 last_word;
  logic                 accept;
  logic [MATCH_W-1:0]   acc_sum;

  lzc32 u_lzc (
    .value (diff_reg[DIGEST_W-1 -: WORD_W]),
    .count (lz_count)
  );

  assign word_mismatch = (lz_count != LZ_W'(WORD_W));
  assign last_word     = (idx_reg == IDX_W'(NUM_WORDS - 1));
  assign accept        = (state_reg == IDLE) && bus.iValid && !bus.iLoadRef;
  // Once a mismatch has been seen, later words must not add to the count.
  assign acc_sum       = acc_reg + (mismatch_seen_reg ? '0 : MATCH_W'(lz_count));

  always_ff @(posedge iClk) begin
    if (!iReset_n) state_reg <= IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = COMPARE;
      COMPARE: begin
`ifdef DIGEST_PREFIX_MATCHER_EARLY_EXIT_EN
        if (word_mismatch || last_word) state_next = REPORT;
`else
        if (last_word) state_next = REPORT;
`endif
      end
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture and word-serial accumulation.
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      ref_reg           <= '0;
      diff_reg          <= '0;
      target_reg        <= '0;
      idx_reg           <= '0;
      acc_reg           <= '0;
      mismatch_seen_reg <= 1'b0;
    end else if (state_reg == IDLE) begin
      if (bus.iLoadRef) begin
        ref_reg <= bus.iDigest;
      end else if (bus.iValid) begin
        diff_reg          <= ref_reg ^ bus.iDigest;
        target_reg        <= bus.iTarget;
        idx_reg           <= '0;
        acc_reg           <= '0;
        mismatch_seen_reg <= 1'b0;
      end
    end else if (state_reg == COMPARE) begin
      diff_reg <= {diff_reg[DIGEST_W-WORD_W-1:0], {WORD_W{1'b0}}};
      idx_reg  <= idx_reg + IDX_W'(1);
      acc_reg  <= acc_sum;
      if (word_mismatch) mismatch_seen_reg <= 1'b1;
    end
  end

  // Results are latched on the edge entering REPORT so they are valid
  // alongside oDone and held until the next result.
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      match_reg <= '0;
      hit_reg   <= 1'b0;
    end else if (state_reg == COMPARE && state_next == REPORT) begin
      match_reg <= acc_sum;
      hit_reg   <= (acc_sum >= target_reg);
    end
  end

  // Hit counter advances on the edge leaving REPORT; a clear in that same
  // cycle wins.
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      count_reg <= '0;
    end else if (bus.iClearCount) begin
      count_reg <= '0;
    end else if (state_reg == REPORT && hit_reg && count_reg != '1) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  // Any iValid not accepted (busy, or colliding with iLoadRef) is dropped.
  always_ff @(posedge iClk) begin
    if (!iReset_n) overrun_reg <= 1'b0;
    else           overrun_reg <= bus.iValid && !accept;
  end

  assign bus.oBusy      = (state_reg != IDLE);
  assign bus.oDone      = (state_reg == REPORT);
  assign bus.oHit       = hit_reg;
  assign bus.oMatchBits = match_reg;
  assign bus.oHitCount  = count_reg;
  assign bus.oOverrun   = overrun_reg;

endmodule
